// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared LC-3b pipeline types used by the hazard sequencer.
// Word/register typedefs plus the sequencer state encoding.
package pipeline_hazard_ctrl_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_reg;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } hazard_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use.sv
// Load-use detector: flags an ID source that depends on a load in EX.
// Purely combinational.
module load_use_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  lc3b_reg id_sr1,
    input  lc3b_reg id_sr2,
    input  logic    id_sr1_used,
    input  logic    id_sr2_used,
    input  lc3b_reg ex_dest,
    input  logic    ex_is_load,
    output logic    hazard
);

    logic hit1;
    logic hit2;

    assign hit1   = id_sr1_used && (id_sr1 == ex_dest);
    assign hit2   = id_sr2_used && (id_sr2 == ex_dest);
    assign hazard = ex_is_load && (hit1 || hit2);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage LC-3b pipeline.
// Arbitrates D-miss, branch redirect, load-use and I-miss.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   icache_resp,
    input  logic                   dmem_req,
    input  logic                   dcache_resp,
    input  lc3b_reg                id_sr1,
    input  lc3b_reg                id_sr2,
    input  logic                   id_sr1_used,
    input  logic                   id_sr2_used,
    input  lc3b_reg                ex_dest,
    input  logic                   ex_is_load,
    input  logic                   br_taken,
    input  lc3b_word               br_target,
    output logic                   load_pc,
    output logic                   pc_sel_redirect,
    output lc3b_word               redirect_pc,
    output logic                   load_if_id,
    output logic                   load_id_ex,
    output logic                   load_ex_mem,
    output logic                   load_mem_wb,
    output logic                   nop_if_id,
    output logic                   nop_id_ex,
    output logic                   nop_ex_mem,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    hazard_state_t          state_q, state_d;
    lc3b_word               target_q, target_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    logic d_miss;
    logic lu_hazard;
    logic lpc, sel;
    logic l_ifid, l_idex, l_exmem, l_memwb;
    logic n_ifid, n_idex, n_exmem;

    load_use_detect u_lu (
        .id_sr1      (id_sr1),
        .id_sr2      (id_sr2),
        .id_sr1_used (id_sr1_used),
        .id_sr2_used (id_sr2_used),
        .ex_dest     (ex_dest),
        .ex_is_load  (ex_is_load),
        .hazard      (lu_hazard)
    );

    assign d_miss = dmem_req && !dcache_resp;

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        redirect_pc = br_target;
        lpc         = 1'b0;
        sel         = 1'b0;
        l_ifid      = 1'b1;
        l_idex      = 1'b1;
        l_exmem     = 1'b1;
        l_memwb     = 1'b1;
        n_ifid      = 1'b0;
        n_idex      = 1'b0;
        n_exmem     = 1'b0;
        unique case (state_q)
            RUN: begin
                if (d_miss) begin
                    l_ifid  = 1'b0;
                    l_idex  = 1'b0;
                    l_exmem = 1'b0;
                    l_memwb = 1'b0;
                end else if (br_taken) begin
                    n_ifid  = 1'b1;
                    n_idex  = 1'b1;
                    n_exmem = 1'b1;
                    // Never abort a pending fetch; park the target instead.
                    if (icache_resp) begin
                        lpc = 1'b1;
                        sel = 1'b1;
                    end else begin
                        target_d = br_target;
                        state_d  = DRAIN;
                    end
                end else if (lu_hazard) begin
                    l_ifid = 1'b0;
                    n_idex = 1'b1;
                end else if (!icache_resp) begin
                    n_ifid = 1'b1;
                end else begin
                    lpc = 1'b1;
                end
            end
            DRAIN: begin
                redirect_pc = target_q;
                n_ifid      = 1'b1;
                if (d_miss) begin
                    l_idex  = 1'b0;
                    l_exmem = 1'b0;
                    l_memwb = 1'b0;
                end
                if (icache_resp) begin
                    lpc     = 1'b1;
                    sel     = 1'b1;
                    state_d = RUN;
                end
            end
            default: ;
        endcase
    end

    assign load_pc         = reset_n && lpc;
    assign pc_sel_redirect = reset_n && sel;
    assign load_if_id      = reset_n && l_ifid;
    assign load_id_ex      = reset_n && l_idex;
    assign load_ex_mem     = reset_n && l_exmem;
    assign load_mem_wb     = reset_n && l_memwb;
    assign nop_if_id       = reset_n && n_ifid;
    assign nop_id_ex       = reset_n && n_idex;
    assign nop_ex_mem      = reset_n && n_exmem;

    always_comb begin
        stall_d = stall_q;
        if (!load_pc && (stall_q != {STALL_CNT_W{1'b1}})) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
    end

    assign stall_cycles = stall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RUN;
            target_q <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            stall_q  <= stall_d;
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage LC-3b pipeline (IF, ID, EX, MEM, WB).
- Drives the load_latch and inject_NOP inputs of every pipeline latch, plus the PC load.
- Arbitrates I-cache misses, D-cache misses, load-use hazards and taken branches resolved in MEM.
- Holds a taken-branch target across an in-flight I-cache fetch so the cache handshake is never aborted.

Parameters:
STALL_CNT_W, 16, width of the saturating stall-cycle performance counter.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
icache_resp  input  1  I-cache delivers the fetch word this cycle.
dmem_req  input  1  MEM stage holds a load or store.
dcache_resp  input  1  D-cache completes the MEM access this cycle.
id_sr1, id_sr2  input  3 each  source registers of the instruction in ID.
id_sr1_used, id_sr2_used  input  1 each  the matching source is actually read.
ex_dest  input  3  destination register of the instruction in EX.
ex_is_load  input  1  EX instruction is LDR/LDB/LDI.
br_taken  input  1  MEM stage resolved a taken branch, JMP, JSR or TRAP.
br_target  input  16  redirect PC (lc3b_word) accompanying br_taken.
load_pc  output  1  PC register load.
pc_sel_redirect  output  1  PC mux selects redirect_pc instead of PC+2.
redirect_pc  output  16  target presented to the PC mux.
load_if_id, load_id_ex, load_ex_mem, load_mem_wb  output  1 each  latch load enables.
nop_if_id, nop_id_ex, nop_ex_mem  output  1 each  inject_NOP into the named latch on its load.
stall_cycles  output  STALL_CNT_W  cycles with load_pc=0; saturates at all-ones.

Behaviour:
- Reset (async, reset_n=0):
  - State goes to RUN and the target register clears to 0.
  - stall_cycles clears to 0.
  - While in reset, all load_* and nop_* outputs and pc_sel_redirect are 0.
- Outputs are combinational from state plus inputs. State, the target register and the counter are registered on the clk rising edge.
- RUN priority, highest first:
  1. D-miss (dmem_req & ~dcache_resp): all load_* = 0, no NOPs. The whole pipe freezes, and a br_taken presented this cycle is ignored and re-presented next cycle.
  2. Branch (br_taken):
     - load_if_id, load_id_ex and load_ex_mem = 1 with nop_if_id, nop_id_ex and nop_ex_mem = 1; load_mem_wb = 1.
     - If icache_resp=1: load_pc=1, pc_sel_redirect=1, redirect_pc=br_target.
     - If icache_resp=0: load_pc=0, latch br_target into the target register, go to DRAIN.
  3. Load-use (ex_is_load and a used ID source equals ex_dest): load_pc=0, load_if_id=0, load_id_ex=1 with nop_id_ex=1, back end loads. One bubble per occurrence.
  4. I-miss (~icache_resp): load_pc=0, load_if_id=1 with nop_if_id=1, rest load normally.
  5. Otherwise all loads are 1 and all NOPs are 0.
- DRAIN (a stale fetch is in flight):
  - load_pc=0. IF/ID loads a NOP every cycle.
  - Back-end latches follow the D-miss rule above; otherwise they load with no NOPs.
  - On icache_resp=1: discard the word (nop_if_id=1), load_pc=1, pc_sel_redirect=1, redirect_pc=target register, return to RUN.
  - br_taken is a don't-care in DRAIN, because the front stages are already bubbles.
- redirect_pc equals br_target in RUN and the target register in DRAIN.
- Counter: stall_cycles increments each cycle load_pc=0 and reset_n=1. It holds at 2^STALL_CNT_W-1.
- Simultaneous D-miss and load-use: the D-miss freeze wins and the hazard is re-evaluated after unfreeze.
- Reset asserted in DRAIN: return to RUN with no redirect pending.

Decomposition:
- Add to lc3b_types: the lc3b_reg (3-bit) typedef if absent, plus a new enum hazard_state_t {RUN, DRAIN}. Reuse lc3b_word.
- One natural sub-module, load_use_detect: purely combinational comparison of sources against ex_dest. Everything else stays in the top module.

Test Plan:
- Reset mid-DRAIN: assert reset_n=0 asynchronously -> state RUN, stall_cycles=0, all loads 0 during reset. Next cycle after release, with icache_resp=1, all loads are 1.
- Load-use: ex_is_load=1, ex_dest=3, id_sr1=3, id_sr1_used=1, icache_resp=1 -> one cycle with load_pc=0, load_if_id=0, nop_id_ex=1. Next cycle all loads are 1 and stall_cycles has incremented by 1.
- D-miss for 4 cycles with br_taken=1 and br_target=x1234 -> all loads 0 for 4 cycles. On dcache_resp=1: flush NOPs on the three latches, load_pc=1, pc_sel_redirect=1, redirect_pc=x1234.
- Branch during I-miss: br_taken=1, br_target=x0040, icache_resp=0 for 3 cycles -> DRAIN with nop_if_id each cycle. On icache_resp=1: load_pc=1, redirect_pc=x0040, word discarded, state RUN.
- Counter saturation with STALL_CNT_W=4: hold an I-miss for 20 cycles -> stall_cycles stops at 15.
- Source unused: id_sr2=ex_dest with id_sr2_used=0 and ex_is_load=1 -> no stall, all loads 1.
